byte_stripe_ctrl: RTL and testbench
===================================

Name: byte_stripe_ctrl

Overview:
Scheduler that feeds the byte-striping datapath. It accepts a single byte stream with valid/ready handshake and deals bytes round-robin onto 1, 2 or 4 active lanes, honouring per-lane backpressure. Lane-count reconfiguration is applied only on word boundaries. The block sits between the link byte source and the per-lane output registers/FIFOs of the striping path.

Parameters:
LANES, 4, number of physical lanes (fixed at 4; lane index 2 bits)
DW, 8, byte width per lane

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low
in_valid  in  1  input byte valid
in_data  in  DW  input byte
in_ready  out  1  block accepts in_data this cycle (combinational)
cfg_lanes  in  2  requested lane count: 00=1, 01=2, 10=4, 11=reserved
cfg_load  in  1  one-cycle strobe to load cfg_lanes
flush  in  1  synchronous abort of a partial word
lane_ready  in  LANES  per-lane sink can take a byte
lane_valid  out  LANES  one-hot per-lane write strobe, registered
lane_data  out  LANES*DW  lane k byte at bits [k*DW +: DW], registered
word_done  out  1  one-cycle pulse: last active lane written this transfer
cur_lane  out  2  lane pointer for next byte
active_cfg  out  2  currently applied cfg code
cfg_err  out  1  sticky: reserved cfg code loaded

Behaviour:
- Reset (async, reset=0): state=IDLE, ptr=0, active_cfg=10 (4 lanes), pending cleared, lane_valid=0, lane_data=0, word_done=0, cfg_err=0, in_ready=0.
- States: IDLE, RUN, HOLD.
- IDLE: in_ready=0. cfg_load with a valid code applies it immediately and moves to RUN next cycle. cfg_load with 11 sets cfg_err and stays in IDLE.
- RUN: in_ready = lane_ready[ptr]. A transfer occurs when in_valid and in_ready are both 1.
  - On transfer: next cycle lane_data[ptr]=in_data and lane_valid = one-hot(ptr) for exactly one cycle. Latency is 1 clock. Other lanes' data is held.
  - ptr increments modulo N (N = 1, 2, 4 per active_cfg).
  - When ptr = N-1, the same next cycle gives word_done=1 and ptr=0.
  - No transfer: lane_valid=0, word_done=0, ptr unchanged.
- cfg_load in RUN with a valid code:
  - If ptr=0 and no transfer this cycle: apply immediately.
  - Otherwise latch as pending and go to HOLD.
- HOLD: behaves as RUN. The transfer that completes the word applies the pending cfg; ptr=0, state returns to RUN.
  - A second cfg_load in HOLD overwrites pending (last wins).
- Reserved code (11) in RUN/HOLD: set cfg_err, ignore the load, keep any earlier pending.
- cfg_err clears only on reset.
- flush (RUN/HOLD): ptr=0, pending applied if present, state=RUN, no word_done. A transfer in the flush cycle is still written, but ptr ends at 0. flush has priority over ptr advance.
- Simultaneous cfg_load and word-completing transfer: the current word finishes with the old N; the new cfg is applied from the next byte.
- lane_ready deasserting mid-word stalls at ptr; there is no skip to other lanes.
- Reset mid-word: all state discarded; the partial word is lost.

Decomposition:
- Shared package `stripe_pkg`:
  - CFG_1LANE=2'b00, CFG_2LANE=2'b01, CFG_4LANE=2'b10, CFG_RSVD=2'b11
  - state encodings IDLE/RUN/HOLD
  - function cfg2n(cfg) returning the lane count
- One natural sub-module: `lane_ptr_counter`, a modulo-N 2-bit counter with advance, clear and wrap outputs. The FSM and output registers stay in the top module.

Test Plan:
1. Reset, then cfg_load=10, all lane_ready=1, stream 0x11,0x22,0x33,0x44,0x55 -> lane_valid 0001,0010,0100,1000,0001 on successive cycles. word_done pulses with the 0x44 write only. lane_data lane0=0x55.
2. cfg 01 (2 lanes), send 0xA0,0xA1,0xA2 -> lanes 0,1,0. word_done after 0xA1. Then lane_ready[1]=0 for 3 cycles -> in_ready=0, no lane_valid, cur_lane=1 held.
3. 4-lane run, after 2 bytes assert cfg_load=00 -> state HOLD, active_cfg stays 10. Bytes 3,4 go to lanes 2,3, then word_done. Next byte goes to lane0 with active_cfg=00, and every byte pulses word_done.
4. In IDLE, cfg_load=11 -> cfg_err=1, in_ready stays 0. Then cfg_load=01 -> RUN. cfg_err remains 1.
5. 4-lane run, 3 bytes sent, flush=1 -> cur_lane=0, no word_done. Next byte 0x77 -> lane0.
6. 4-lane run, drop reset mid-word (after lane1 write) -> all outputs 0 asynchronously, active_cfg=10, state IDLE, in_ready=0.

Source files
------------

// File: rtl/byte_stripe_ctrl_pkg.sv
// Shared constants, state encoding and cfg decode for the byte-striping scheduler.
package stripe_pkg;
   localparam int LANES = 4;
   localparam int DW    = 8;

   localparam logic [1:0] CFG_1LANE = 2'b00;
   localparam logic [1:0] CFG_2LANE = 2'b01;
   localparam logic [1:0] CFG_4LANE = 2'b10;
   localparam logic [1:0] CFG_RSVD  = 2'b11;

   // HOLD means a cfg change is waiting for the current word to finish
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [2:0] cfg2n(input logic [1:0] cfg);
      case (cfg)
         CFG_1LANE: return 3'd1;
         CFG_2LANE: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction
endpackage

// File: rtl/byte_stripe_ctrl_if.sv
// Byte-stream input and per-lane output bus of the striping scheduler.
interface byte_stripe_ctrl_if #(
   parameter int LANES = stripe_pkg::LANES,
   parameter int DW    = stripe_pkg::DW
);
   logic                       in_valid;
   logic [DW-1:0]              in_data;
   logic                       in_ready;
   logic [LANES-1:0]           lane_ready;
   logic [LANES-1:0]           lane_valid;
   logic [LANES-1:0][DW-1:0]   lane_data;
   logic                       word_done;

   modport master (
      output in_valid, in_data, lane_ready,
      input  in_ready, lane_valid, lane_data, word_done
   );

   modport slave (
      input  in_valid, in_data, lane_ready,
      output in_ready, lane_valid, lane_data, word_done
   );
endinterface

// File: rtl/byte_stripe_ctrl_ptr.sv
// Modulo-N lane pointer: advances on each accepted byte, wraps after i_last.
module lane_ptr_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_adv,
   input  logic       i_clr,
   input  logic [1:0] i_last,
   output logic [1:0] o_ptr,
   output logic       o_wrap
);
   logic [1:0] r_ptr;

   assign o_ptr  = r_ptr;
   assign o_wrap = i_adv & (r_ptr == i_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ptr <= 2'd0;
      else if (i_clr || o_wrap)
         r_ptr <= 2'd0;
      else if (i_adv)
         r_ptr <= r_ptr + 2'd1;
   end
endmodule

// File: rtl/byte_stripe_ctrl.sv
// Deals an input byte stream round-robin onto 1/2/4 lanes; lane-count
// changes take effect only on word boundaries (or on flush).
module byte_stripe_ctrl
   import stripe_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   byte_stripe_ctrl_if.slave  bus,
   input  logic [1:0]         i_cfg_lanes,
   input  logic               i_cfg_load,
   input  logic               i_flush,
   output logic [1:0]         o_cur_lane,
   output logic [1:0]         o_active_cfg,
   output logic               o_cfg_err
);
   state_t                   r_state, w_state_nxt;
   logic [1:0]               r_active_cfg, w_active_nxt;
   logic [1:0]               r_pend_cfg, w_pend_nxt;
   logic                     r_cfg_err, w_err_nxt;
   logic [LANES-1:0]         r_lane_valid;
   logic [LANES-1:0][DW-1:0] r_lane_data;
   logic                     r_word_done;

   logic [1:0] w_ptr, w_last_idx;
   logic       w_run, w_xfer, w_wrap, w_flush, w_cfg_ok, w_cfg_bad;

   assign w_run      = (r_state != IDLE);
   assign bus.in_ready = w_run & bus.lane_ready[w_ptr];
   assign w_xfer     = bus.in_valid & bus.in_ready;
   assign w_flush    = w_run & i_flush;
   assign w_cfg_ok   = i_cfg_load & (i_cfg_lanes != CFG_RSVD);
   assign w_cfg_bad  = i_cfg_load & (i_cfg_lanes == CFG_RSVD);
   assign w_last_idx = 2'(cfg2n(r_active_cfg) - 3'd1);

   lane_ptr_counter u_ptr (
      .clk    (clk),
      .reset  (reset),
      .i_adv  (w_xfer),
      .i_clr  (w_flush),
      .i_last (w_last_idx),
      .o_ptr  (w_ptr),
      .o_wrap (w_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_active_cfg <= CFG_4LANE;
         r_pend_cfg   <= CFG_1LANE;
         r_cfg_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_active_cfg <= w_active_nxt;
         r_pend_cfg   <= w_pend_nxt;
         r_cfg_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_active_nxt = r_active_cfg;
      w_pend_nxt   = r_pend_cfg;
      w_err_nxt    = r_cfg_err | w_cfg_bad;
      case (r_state)
         IDLE: begin
            if (w_cfg_ok) begin
               w_active_nxt = i_cfg_lanes;
               w_state_nxt  = RUN;
            end
         end
         RUN, HOLD: begin
            if (i_flush) begin
               if (r_state == HOLD) w_active_nxt = r_pend_cfg;
               if (w_cfg_ok)        w_active_nxt = i_cfg_lanes;
               w_state_nxt = RUN;
            end else if (w_wrap) begin
               // a load arriving with the last byte is newer than any pending one
               if (w_cfg_ok)             w_active_nxt = i_cfg_lanes;
               else if (r_state == HOLD) w_active_nxt = r_pend_cfg;
               w_state_nxt = RUN;
            end else if (w_cfg_ok) begin
               if (r_state == RUN && w_ptr == 2'd0 && !w_xfer) begin
                  w_active_nxt = i_cfg_lanes;
               end else begin
                  w_pend_nxt  = i_cfg_lanes;
                  w_state_nxt = HOLD;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lane_valid <= '0;
         r_lane_data  <= '0;
         r_word_done  <= 1'b0;
      end else begin
         r_lane_valid <= w_xfer ? ({{(LANES-1){1'b0}}, 1'b1} << w_ptr) : '0;
         r_word_done  <= w_wrap & ~w_flush;
         if (w_xfer) r_lane_data[w_ptr] <= bus.in_data;
      end
   end

   assign bus.lane_valid = r_lane_valid;
   assign bus.lane_data  = r_lane_data;
   assign bus.word_done  = r_word_done;
   assign o_cur_lane     = w_ptr;
   assign o_active_cfg   = r_active_cfg;
   assign o_cfg_err      = r_cfg_err;
endmodule

// File: tb/tb_byte_stripe_ctrl.sv
// Directed scenarios plus randomized traffic against a word/position model.
module tb_byte_stripe_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] cfg_lanes = 2'b00;
   logic       cfg_load = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] cur_lane, active_cfg;
   logic       cfg_err;

   byte_stripe_ctrl_if bus();

   byte_stripe_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .i_cfg_lanes  (cfg_lanes),
      .i_cfg_load   (cfg_load),
      .i_flush      (flush),
      .o_cur_lane   (cur_lane),
      .o_active_cfg (active_cfg),
      .o_cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: a word is m_n bytes long, m_pos is how many bytes of it are in
   bit         m_run, m_haspend, m_err, m_wd, exp_ready;
   int         m_pos, m_cfg, m_pend;
   logic [3:0] m_lv;
   logic [7:0] m_data [4];
   logic       obs_ready;

   task automatic model_reset();
      m_run = 0; m_haspend = 0; m_err = 0; m_wd = 0;
      m_pos = 0; m_cfg = 2; m_pend = 0; m_lv = '0;
      foreach (m_data[k]) m_data[k] = '0;
   endtask

   task automatic model_step(input logic iv, input logic [7:0] id, input logic cld,
                             input logic [1:0] cl, input logic fl);
      bit xfer, done, good;
      int n;
      n = 1 << m_cfg;
      exp_ready = m_run && bus.lane_ready[m_pos];
      xfer = iv && exp_ready;
      good = cld && (cl != 2'b11);
      if (cld && cl == 2'b11) m_err = 1;
      m_lv = '0; m_wd = 0;
      if (xfer) begin
         m_data[m_pos] = id;
         m_lv = 4'(1 << m_pos);
      end
      done = xfer && (m_pos == n - 1);
      if (!m_run) begin
         if (good) begin m_cfg = int'(cl); m_run = 1; end
      end else if (fl) begin
         if (m_haspend) m_cfg = m_pend;
         if (good) m_cfg = int'(cl);
         m_haspend = 0; m_pos = 0;
      end else if (done) begin
         m_wd = 1; m_pos = 0;
         if (good) m_cfg = int'(cl);
         else if (m_haspend) m_cfg = m_pend;
         m_haspend = 0;
      end else begin
         if (good) begin
            if (!m_haspend && m_pos == 0 && !xfer) m_cfg = int'(cl);
            else begin m_pend = int'(cl); m_haspend = 1; end
         end
         if (xfer) m_pos++;
      end
   endtask

   // called at posedge+1; returns at the next posedge+1 with strobes dropped
   task automatic cyc(input logic iv, input logic [7:0] id, input logic cld,
                      input logic [1:0] cl, input logic fl);
      bus.in_valid = iv; bus.in_data = id;
      cfg_load = cld; cfg_lanes = cl; flush = fl;
      @(negedge clk);
      obs_ready = bus.in_ready;
      model_step(iv, id, cld, cl, fl);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; cfg_load = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.lane_ready = '1;
      cfg_load = 1'b0; flush = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.lane_valid !== 4'b0) begin errors++; $display("FAIL rst_lane_valid got %b exp 0000", bus.lane_valid); end
      checks++; if (bus.lane_data !== 32'h0) begin errors++; $display("FAIL rst_lane_data got %h exp 0", bus.lane_data); end
      checks++; if (bus.word_done !== 1'b0) begin errors++; $display("FAIL rst_word_done got %b exp 0", bus.word_done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
      checks++; if (active_cfg !== 2'b10) begin errors++; $display("FAIL rst_active_cfg got %b exp 10", active_cfg); end
      checks++; if (cur_lane !== 2'd0 || cfg_err !== 1'b0) begin errors++; $display("FAIL rst_ptr_err got %0d/%b exp 0/0", cur_lane, cfg_err); end
   endtask

   task automatic test_four_lane();
      logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [3:0] lv_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      cyc(0, 8'h00, 1, 2'b10, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, bytes[i], 0, 2'b00, 0);
         checks++; if (bus.lane_valid !== lv_exp[i]) begin errors++; $display("FAIL four_lv[%0d] got %b exp %b", i, bus.lane_valid, lv_exp[i]); end
         checks++; if (bus.word_done !== (i == 3)) begin errors++; $display("FAIL four_wd[%0d] got %b exp %b", i, bus.word_done, (i == 3)); end
      end
      checks++; if (bus.lane_data[0] !== 8'h55) begin errors++; $display("FAIL four_lane0 got %h exp 55", bus.lane_data[0]); end
      checks++; if (bus.lane_data[3] !== 8'h44) begin errors++; $display("FAIL four_lane3 got %h exp 44", bus.lane_data[3]); end
   endtask

   task automatic test_two_lane_stall();
      logic [3:0] lv_exp [3] = '{4'b0001, 4'b0010, 4'b0001};
      do_reset();
      cyc(0, 8'h00, 1, 2'b01, 0);
      checks++; if (active_cfg !== 2'b01) begin errors++; $display("FAIL two_cfg got %b exp 01", active_cfg); end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 8'hA0 + 8'(i), 0, 2'b00, 0);
         checks++; if (bus.lane_valid !== lv_exp[i]) begin errors++; $display("FAIL two_lv[%0d] got %b exp %b", i, bus.lane_valid, lv_exp[i]); end
         checks++; if (bus.word_done !== (i == 1)) begin errors++; $display("FAIL two_wd[%0d] got %b exp %b", i, bus.word_done, (i == 1)); end
      end
      bus.lane_ready = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 8'hA3, 0, 2'b00, 0);
         checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, obs_ready); end
         checks++; if (bus.lane_valid !== 4'b0 || cur_lane !== 2'd1) begin errors++; $display("FAIL stall_hold[%0d] got %b/%0d exp 0000/1", i, bus.lane_valid, cur_lane); end
      end
      bus.lane_ready = 4'b1111;
      cyc(1, 8'hA3, 0, 2'b00, 0);
      checks++; if (bus.lane_valid !== 4'b0010 || bus.word_done !== 1'b1) begin errors++; $display("FAIL stall_resume got %b/%b exp 0010/1", bus.lane_valid, bus.word_done); end
   endtask

   task automatic test_reconfig_hold();
      do_reset();
      cyc(0, 8'h00, 1, 2'b10, 0);
      cyc(1, 8'hB0, 0, 2'b00, 0);
      cyc(1, 8'hB1, 0, 2'b00, 0);
      cyc(0, 8'h00, 1, 2'b00, 0);
      checks++; if (active_cfg !== 2'b10 || cur_lane !== 2'd2) begin errors++; $display("FAIL hold_cfg got %b/%0d exp 10/2", active_cfg, cur_lane); end
      cyc(1, 8'hB2, 0, 2'b00, 0);
      checks++; if (bus.lane_valid !== 4'b0100 || bus.word_done !== 1'b0) begin errors++; $display("FAIL hold_b2 got %b/%b exp 0100/0", bus.lane_valid, bus.word_done); end
      cyc(1, 8'hB3, 0, 2'b00, 0);
      checks++; if (bus.lane_valid !== 4'b1000 || bus.word_done !== 1'b1) begin errors++; $display("FAIL hold_b3 got %b/%b exp 1000/1", bus.lane_valid, bus.word_done); end
      checks++; if (active_cfg !== 2'b00 || cur_lane !== 2'd0) begin errors++; $display("FAIL hold_apply got %b/%0d exp 00/0", active_cfg, cur_lane); end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 8'hC0 + 8'(i), 0, 2'b00, 0);
         checks++; if (bus.lane_valid !== 4'b0001 || bus.word_done !== 1'b1) begin errors++; $display("FAIL one_lane[%0d] got %b/%b exp 0001/1", i, bus.lane_valid, bus.word_done); end
      end
   endtask

   task automatic test_cfg_err();
      do_reset();
      cyc(0, 8'h00, 1, 2'b11, 0);
      checks++; if (cfg_err !== 1'b1 || active_cfg !== 2'b10) begin errors++; $display("FAIL err_set got %b/%b exp 1/10", cfg_err, active_cfg); end
      cyc(1, 8'h5A, 0, 2'b00, 0);
      checks++; if (obs_ready !== 1'b0 || bus.lane_valid !== 4'b0) begin errors++; $display("FAIL err_idle got %b/%b exp 0/0000", obs_ready, bus.lane_valid); end
      cyc(0, 8'h00, 1, 2'b01, 0);
      cyc(1, 8'h5B, 0, 2'b00, 0);
      checks++; if (obs_ready !== 1'b1 || bus.lane_valid !== 4'b0001) begin errors++; $display("FAIL err_run got %b/%b exp 1/0001", obs_ready, bus.lane_valid); end
      checks++; if (cfg_err !== 1'b1 || active_cfg !== 2'b01) begin errors++; $display("FAIL err_sticky got %b/%b exp 1/01", cfg_err, active_cfg); end
   endtask

   task automatic test_flush();
      do_reset();
      cyc(0, 8'h00, 1, 2'b10, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'hD0 + 8'(i), 0, 2'b00, 0);
      checks++; if (cur_lane !== 2'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", cur_lane); end
      cyc(0, 8'h00, 0, 2'b00, 1);
      checks++; if (cur_lane !== 2'd0 || bus.word_done !== 1'b0) begin errors++; $display("FAIL flush_ptr got %0d/%b exp 0/0", cur_lane, bus.word_done); end
      cyc(1, 8'h77, 0, 2'b00, 0);
      checks++; if (bus.lane_valid !== 4'b0001 || bus.lane_data[0] !== 8'h77) begin errors++; $display("FAIL flush_next got %b/%h exp 0001/77", bus.lane_valid, bus.lane_data[0]); end
      cyc(1, 8'h78, 0, 2'b00, 1);
      checks++; if (bus.lane_valid !== 4'b0010 || bus.lane_data[1] !== 8'h78) begin errors++; $display("FAIL flush_xfer got %b/%h exp 0010/78", bus.lane_valid, bus.lane_data[1]); end
      checks++; if (cur_lane !== 2'd0 || bus.word_done !== 1'b0) begin errors++; $display("FAIL flush_xfer_ptr got %0d/%b exp 0/0", cur_lane, bus.word_done); end
   endtask

   task automatic test_reset_midword();
      do_reset();
      cyc(0, 8'h00, 1, 2'b10, 0);
      cyc(1, 8'hE0, 0, 2'b00, 0);
      cyc(0, 8'h00, 1, 2'b11, 0);
      cyc(1, 8'hE1, 0, 2'b00, 0);
      checks++; if (bus.lane_valid !== 4'b0010 || cfg_err !== 1'b1) begin errors++; $display("FAIL mid_pre got %b/%b exp 0010/1", bus.lane_valid, cfg_err); end
      reset = 1'b0;
      #1;
      checks++; if (bus.lane_valid !== 4'b0 || bus.lane_data !== 32'h0 || bus.word_done !== 1'b0) begin errors++; $display("FAIL mid_out got %b/%h/%b exp 0/0/0", bus.lane_valid, bus.lane_data, bus.word_done); end
      checks++; if (cur_lane !== 2'd0 || active_cfg !== 2'b10 || cfg_err !== 1'b0) begin errors++; $display("FAIL mid_state got %0d/%b/%b exp 0/10/0", cur_lane, active_cfg, cfg_err); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", bus.in_ready); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      logic       iv, cld, fl;
      logic [7:0] id;
      logic [1:0] cl;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if (i % 500 == 499) do_reset();
         bus.lane_ready = 4'($urandom);
         iv  = ($urandom_range(0, 3) != 0);
         id  = 8'($urandom);
         cld = ($urandom_range(0, 7) == 0);
         cl  = 2'($urandom);
         fl  = ($urandom_range(0, 15) == 0);
         cyc(iv, id, cld, cl, fl);
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, obs_ready, exp_ready); end
         checks++; if (bus.lane_valid !== m_lv) begin errors++; $display("FAIL rnd_lv[%0d] got %b exp %b", i, bus.lane_valid, m_lv); end
         checks++; if (bus.word_done !== m_wd) begin errors++; $display("FAIL rnd_wd[%0d] got %b exp %b", i, bus.word_done, m_wd); end
         checks++; if (cur_lane !== 2'(m_pos)) begin errors++; $display("FAIL rnd_ptr[%0d] got %0d exp %0d", i, cur_lane, m_pos); end
         checks++; if (active_cfg !== 2'(m_cfg) || cfg_err !== m_err) begin errors++; $display("FAIL rnd_cfg[%0d] got %b/%b exp %b/%b", i, active_cfg, cfg_err, 2'(m_cfg), m_err); end
         checks++; if (bus.lane_data !== {m_data[3], m_data[2], m_data[1], m_data[0]}) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, bus.lane_data, {m_data[3], m_data[2], m_data[1], m_data[0]}); end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.lane_ready = '1;
      model_reset();
      #2;
      test_reset();
      test_four_lane();
      test_two_lane_stall();
      test_reconfig_hold();
      test_cfg_err();
      test_flush();
      test_reset_midword();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
